// File: rtl/capture_ctrl.sv
// capture_ctrl: write-side controller for the five per-channel sample RAMqueues.
// It runs a circular capture of decimated samples and raises armed once enough
// pre-trigger history is stored. After the trigger it keeps trig_pos further samples,
// then stops and pulses set_capture_done. When it stops, waddr points at the oldest
// stored sample, which is where the channel dump starts.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   wrt_smpl          1-cycle pulse: a new decimated sample is valid
//   run               capture enabled
//   capture_done      sticky done flag owned by cmd_cfg; the host clears it
//   triggered         trigger level; only honoured while armed
//   trig_pos          number of post-trigger samples to keep (clamped to ENTRIES-1)
//   we                write enable shared by all RAMqueues (combinational from wrt_smpl)
//   waddr             RAM write pointer; frozen on the oldest sample once done
//   set_capture_done  1-cycle pulse when the capture completes
//   armed             pre-trigger history is full, so the trigger may fire
//   capturing         high while a capture is running
module capture_ctrl #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned AW      = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrt_smpl,
  input  logic          run,
  input  logic          capture_done,
  input  logic          triggered,
  input  logic [AW-1:0] trig_pos,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          set_capture_done,
  output logic          armed,
  output logic          capturing
);

  // Counters need one extra bit so they can hold ENTRIES itself.
  localparam int unsigned      CW       = AW + 1;
  localparam logic [CW-1:0]    EntriesC = CW'(ENTRIES);
  localparam logic [AW-1:0]    LastAddr = AW'(ENTRIES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] smpl_cnt_q;
  logic [CW-1:0] trig_cnt_q;
  logic          trig_seen_q;

  logic [AW-1:0] trig_pos_eff;
  logic [CW-1:0] arm_thresh;
  logic [CW-1:0] smpl_cnt_nx;
  logic [CW-1:0] trig_cnt_nx;
  logic          trig_seen_nx;
  logic          in_run;
  logic          wr;
  logic          finish;

  always_comb begin
    trig_pos_eff = ({1'b0, trig_pos} >= EntriesC) ? LastAddr : trig_pos;
    arm_thresh   = EntriesC - {1'b0, trig_pos_eff};
    in_run       = (state_q == StRun);
    trig_seen_nx = trig_seen_q | (armed & triggered);
    // With zero post-trigger samples, the trigger cycle must not write.
    // Otherwise the oldest sample would be overwritten.
    wr           = in_run & wrt_smpl & ~(trig_seen_nx & (trig_pos_eff == '0));

    smpl_cnt_nx = smpl_cnt_q;
    if (wr && (smpl_cnt_q != EntriesC)) smpl_cnt_nx = smpl_cnt_q + 1'b1;

    trig_cnt_nx = trig_cnt_q;
    if (wr && trig_seen_nx) trig_cnt_nx = trig_cnt_q + 1'b1;

    finish = trig_seen_nx & (trig_cnt_nx == {1'b0, trig_pos_eff});
  end

  assign we        = wr;
  assign capturing = in_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      waddr            <= '0;
      smpl_cnt_q       <= '0;
      trig_cnt_q       <= '0;
      trig_seen_q      <= 1'b0;
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
    end else begin
      set_capture_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          armed <= 1'b0;
          if (run && !capture_done) begin
            state_q     <= StRun;
            waddr       <= '0;
            smpl_cnt_q  <= '0;
            trig_cnt_q  <= '0;
            trig_seen_q <= 1'b0;
          end
        end
        StRun: begin
          if (wr) waddr <= (waddr == LastAddr) ? '0 : waddr + 1'b1;
          if (!run) begin
            state_q <= StIdle;
            armed   <= 1'b0;
          end else begin
            smpl_cnt_q  <= smpl_cnt_nx;
            trig_cnt_q  <= trig_cnt_nx;
            trig_seen_q <= trig_seen_nx;
            armed       <= armed | (smpl_cnt_nx >= arm_thresh);
            if (finish) begin
              state_q          <= StDone;
              set_capture_done <= 1'b1;
              armed            <= 1'b0;
            end
          end
        end
        StDone: begin
          // The flag is only set by our own pulse, so it cannot be seen during the pulse cycle.
          if (!set_capture_done && !capture_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: scoreboard bench for capture_ctrl.
// The stimulus pushes the expected (cycle, address) of every write and every done pulse.
// A negedge monitor compares we and set_capture_done against the head of those queues on
// every cycle.
module tb_capture_ctrl;

  localparam int ENTRIES = 384;
  localparam int AW      = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wrt_smpl;
  logic          run;
  logic          capture_done;
  logic          triggered;
  logic [AW-1:0] trig_pos;
  logic          we;
  logic [AW-1:0] waddr;
  logic          set_capture_done;
  logic          armed;
  logic          capturing;

  capture_ctrl #(
    .ENTRIES(ENTRIES),
    .AW     (AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wrt_smpl        (wrt_smpl),
    .run             (run),
    .capture_done    (capture_done),
    .triggered       (triggered),
    .trig_pos        (trig_pos),
    .we              (we),
    .waddr           (waddr),
    .set_capture_done(set_capture_done),
    .armed           (armed),
    .capturing       (capturing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_addr  = 0;
  int wq_cyc[$];
  int wq_addr[$];
  int dq_cyc[$];
  int dq_addr[$];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Monitor: compare DUT outputs with the scoreboard head on every cycle.
  bit exp_w;
  bit exp_d;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_w = (wq_cyc.size() > 0) && (wq_cyc[0] == cyc);
      chk("we", int'(we), int'(exp_w));
      if (exp_w) begin
        chk("waddr_on_write", int'(waddr), wq_addr[0]);
        void'(wq_cyc.pop_front());
        void'(wq_addr.pop_front());
      end
      exp_d = (dq_cyc.size() > 0) && (dq_cyc[0] == cyc);
      chk("set_capture_done", int'(set_capture_done), int'(exp_d));
      if (exp_d) begin
        chk("waddr_at_done", int'(waddr), dq_addr[0]);
        void'(dq_cyc.pop_front());
        void'(dq_addr.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle; when a write is expected, record its cycle and address first.
  task automatic drive(input logic w, input bit exp_we);
    wrt_smpl = w;
    if (exp_we) begin
      wq_cyc.push_back(cyc);
      wq_addr.push_back(exp_addr);
      exp_addr = (exp_addr == ENTRIES - 1) ? 0 : exp_addr + 1;
    end
    step();
  endtask

  // The current cycle is expected to carry the done pulse.
  task automatic expect_done();
    dq_cyc.push_back(cyc);
    dq_addr.push_back(exp_addr);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    run          = 1'b0;
    wrt_smpl     = 1'b0;
    triggered    = 1'b0;
    capture_done = 1'b0;
    trig_pos     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic start(input int tp);
    trig_pos = AW'(tp);
    run      = 1'b1;
    exp_addr = 0;
    drive(1'b0, 1'b0);
  endtask

  task automatic leftovers(input string tag);
    step();
    chk({tag, "_writes_pending"}, wq_cyc.size(), 0);
    chk({tag, "_done_pending"}, dq_cyc.size(), 0);
  endtask

  initial begin
    do_reset();
    chk("reset_waddr", int'(waddr), 0);
    chk("reset_armed", int'(armed), 0);
    chk("reset_capturing", int'(capturing), 0);

    // T1: asynchronous reset mid-capture, while armed.
    start(383);
    repeat (10) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk("t1_armed_before_rst", int'(armed), 1);
    chk("t1_capturing_before_rst", int'(capturing), 1);
    chk("t1_waddr_before_rst", int'(waddr), 10);
    #2;
    wrt_smpl = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("t1_async_we", int'(we), 0);
    chk("t1_async_waddr", int'(waddr), 0);
    chk("t1_async_armed", int'(armed), 0);
    chk("t1_async_capturing", int'(capturing), 0);
    chk("t1_async_done", int'(set_capture_done), 0);
    run = 1'b0;
    wrt_smpl = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b0);
    leftovers("t1");

    // T2: trig_pos=10; arm after 374 writes; trigger 5 writes later; 10 post writes, wrap.
    do_reset();
    start(10);
    repeat (373) drive(1'b1, 1'b1);
    chk("t2_armed_at_373", int'(armed), 0);
    drive(1'b1, 1'b1);
    chk("t2_armed_at_374", int'(armed), 1);
    repeat (5) drive(1'b1, 1'b1);
    triggered = 1'b1;
    repeat (10) drive(1'b1, 1'b1);
    expect_done();
    capture_done = 1'b1;
    triggered    = 1'b0;
    repeat (3) drive(1'b1, 1'b0);
    chk("t2_done_capturing", int'(capturing), 0);
    chk("t2_done_armed", int'(armed), 0);
    chk("t2_done_waddr", int'(waddr), 5);
    leftovers("t2");

    // T3: trig_pos=0; arm after a full buffer; done the cycle after trigger, no write.
    do_reset();
    start(0);
    repeat (383) drive(1'b1, 1'b1);
    chk("t3_armed_at_383", int'(armed), 0);
    drive(1'b1, 1'b1);
    chk("t3_armed_at_384", int'(armed), 1);
    chk("t3_waddr_wrapped", int'(waddr), 0);
    triggered = 1'b1;
    drive(1'b1, 1'b0);
    expect_done();
    capture_done = 1'b1;
    triggered    = 1'b0;
    repeat (2) drive(1'b1, 1'b0);
    chk("t3_done_waddr", int'(waddr), 0);
    leftovers("t3");

    // T4: trigger held from the start; ignored until armed at write 284; trigger sampled in a gap.
    do_reset();
    triggered = 1'b1;
    start(100);
    repeat (284) drive(1'b1, 1'b1);
    chk("t4_armed_at_284", int'(armed), 1);
    repeat (3) drive(1'b0, 1'b0);
    repeat (100) drive(1'b1, 1'b1);
    expect_done();
    capture_done = 1'b1;
    triggered    = 1'b0;
    repeat (2) drive(1'b0, 1'b0);
    chk("t4_done_waddr", int'(waddr), 0);
    leftovers("t4");

    // T5: run drops mid-capture -> idle, no done pulse; restart clears the pointer.
    do_reset();
    start(10);
    repeat (20) drive(1'b1, 1'b1);
    run = 1'b0;
    drive(1'b0, 1'b0);
    chk("t5_stop_capturing", int'(capturing), 0);
    chk("t5_stop_armed", int'(armed), 0);
    repeat (2) drive(1'b1, 1'b0);
    start(10);
    repeat (3) drive(1'b1, 1'b1);
    chk("t5_restart_waddr", int'(waddr), 3);
    run = 1'b0;
    drive(1'b0, 1'b0);
    leftovers("t5");

    // T6: trig_pos=500 clamps to 383; a sample every 3rd cycle; then DONE hold and host clear.
    do_reset();
    start(500);
    for (int k = 0; k < 385; k++) begin
      triggered = (k >= 2);
      drive(1'b1, 1'b1);
      if (k == 0) chk("t6_armed_after_1", int'(armed), 1);
      if (k == 384) begin
        expect_done();
        capture_done = 1'b1;
      end
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
    end
    triggered = 1'b0;
    repeat (5) drive(1'b1, 1'b0);
    chk("t6_hold_capturing", int'(capturing), 0);
    chk("t6_hold_waddr", int'(waddr), 1);
    capture_done = 1'b0;
    drive(1'b0, 1'b0);
    chk("t6_cleared_idle", int'(capturing), 0);
    drive(1'b0, 1'b0);
    chk("t6_rerun_capturing", int'(capturing), 1);
    chk("t6_rerun_waddr", int'(waddr), 0);
    run = 1'b0;
    drive(1'b0, 1'b0);
    leftovers("t6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
